// File: rtl/pattern_mode_sequencer.sv
// Pattern mode sequencer: debounced button / auto-cycle stepping of the
// kaleidoscope pattern mode, applied only on frame boundaries with video muted
// around the change so no torn frame reaches the HDMI encoder.
module pattern_mode_sequencer #(
  parameter int C_debounce_bits  = 16,
  parameter int C_modes          = 8,
  parameter int C_reset_mode     = 4,
  parameter int C_mute_frames    = 2,
  parameter int C_auto_frames    = 0,
  parameter int C_vs_active_high = 1
) (
  input  logic       clk_pixel_i,
  input  logic       reset_n_i,
  input  logic       btn_i,
  input  logic       vsync_i,
  output logic [2:0] mode_o,
  output logic       mute_o,
  output logic       mode_strobe_o,
  output logic       busy_o
);

  localparam int DW = C_debounce_bits;
  localparam logic [DW-1:0] DEB_MAX   = '1;
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [2:0]    MODE_RST  = 3'(C_reset_mode);
  localparam logic [2:0]    MODE_LAST = 3'(C_modes - 1);
  localparam logic [3:0]    MUTE_LOAD = 4'(C_mute_frames);
  localparam bit            AUTO_EN   = (C_auto_frames != 0);
  localparam logic [11:0]   AUTO_LAST = 12'(C_auto_frames - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MUTE_PRE, S_MUTE} state_t;

  state_t         state_q;
  logic           btn_s1_q, btn_s2_q, btn_s3_q;
  logic [DW-1:0]  deb_cnt_q;
  logic           deb_q, deb_prev_q;
  logic           vs_act_q;
  logic [11:0]    auto_cnt_q;
  logic [2:0]     mode_q;
  logic [3:0]     frm_cnt_q;
  logic           mute_q, strobe_q, busy_q, pending_q;

  logic vs_act, frame_edge, press, auto_req;

  // Pin-level vsync mapped to "pulse active" so the edge logic is polarity-free.
  assign vs_act     = (C_vs_active_high != 0) ? vsync_i : ~vsync_i;
  assign frame_edge = vs_act & ~vs_act_q;
  assign press      = deb_q & ~deb_prev_q;
  assign auto_req   = AUTO_EN && (state_q == S_IDLE) && frame_edge && (auto_cnt_q == AUTO_LAST);

  // Button synchronizer and debouncer; counter restarts on any synced-level change.
  always_ff @(posedge clk_pixel_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_s3_q   <= 1'b0;
      deb_cnt_q  <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
    end else begin
      btn_s1_q   <= btn_i;
      btn_s2_q   <= btn_s1_q;
      btn_s3_q   <= btn_s2_q;
      deb_prev_q <= deb_q;
      if (btn_s2_q != btn_s3_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q != DEB_MAX) begin
        deb_cnt_q <= deb_cnt_q + DEB_ONE;
        // Level is accepted on the cycle the counter saturates.
        if (deb_cnt_q == DEB_MAX - DEB_ONE) deb_q <= btn_s2_q;
      end
    end
  end

  // Registered vsync copy for frame-edge detection.
  always_ff @(posedge clk_pixel_i or negedge reset_n_i) begin
    if (!reset_n_i) vs_act_q <= 1'b0;
    else            vs_act_q <= vs_act;
  end

  // Auto-cycle timer: counts frame edges only while idle.
  always_ff @(posedge clk_pixel_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      auto_cnt_q <= '0;
    end else if (state_q != S_IDLE) begin
      auto_cnt_q <= '0;
    end else if (AUTO_EN && frame_edge) begin
      auto_cnt_q <= auto_req ? 12'd0 : auto_cnt_q + 12'd1;
    end
  end

  // Change sequencer: arm, mute on next edge, switch mode on the following edge, hold mute.
  always_ff @(posedge clk_pixel_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_RST;
      frm_cnt_q <= '0;
      mute_q    <= 1'b0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      // One-deep queue of presses that arrive mid-change.
      if (state_q != S_IDLE && press) pending_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (press || auto_req) begin
            state_q <= S_ARM;
            busy_q  <= 1'b1;
          end
        end
        S_ARM: begin
          if (frame_edge) begin
            mute_q  <= 1'b1;
            state_q <= S_MUTE_PRE;
          end
        end
        S_MUTE_PRE: begin
          if (frame_edge) begin
            mode_q    <= (mode_q == MODE_LAST) ? 3'd0 : mode_q + 3'd1;
            strobe_q  <= 1'b1;
            frm_cnt_q <= MUTE_LOAD;
            state_q   <= S_MUTE;
          end
        end
        S_MUTE: begin
          if (frame_edge) begin
            frm_cnt_q <= frm_cnt_q - 4'd1;
            if (frm_cnt_q == 4'd1) begin
              mute_q <= 1'b0;
              // A queued press skips idle and re-arms on the same cycle.
              if (pending_q || press) begin
                pending_q <= 1'b0;
                state_q   <= S_ARM;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mode_o        = mode_q;
  assign mute_o        = mute_q;
  assign mode_strobe_o = strobe_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_pattern_mode_sequencer.sv
// Directed bench for pattern_mode_sequencer: instance A (8 modes, button driven)
// and instance B (5 modes, auto-cycle every 3 frames) share clock, reset, vsync.
module tb_pattern_mode_sequencer;

  logic clk = 1'b0, rst_n = 1'b0, btn = 1'b0, btn_b = 1'b0;
  logic vsync;
  logic [2:0] mode_a, mode_b;
  logic mute_a, strobe_a, busy_a, mute_b, strobe_b, busy_b;

  int pix_cnt = 0, frame_no = 0;
  int checks = 0, failures = 0;
  int exp_mode_a = 4;
  logic [2:0] exp_q[$];
  logic [2:0] exp_b_q[$];
  logic [2:0] obs_b_mode[$];
  int         obs_b_frame[$];

  pattern_mode_sequencer #(.C_debounce_bits(3), .C_modes(8), .C_reset_mode(4),
    .C_mute_frames(2), .C_auto_frames(0), .C_vs_active_high(1)) u_a (
    .clk_pixel_i(clk), .reset_n_i(rst_n), .btn_i(btn), .vsync_i(vsync),
    .mode_o(mode_a), .mute_o(mute_a), .mode_strobe_o(strobe_a), .busy_o(busy_a));

  pattern_mode_sequencer #(.C_debounce_bits(3), .C_modes(5), .C_reset_mode(4),
    .C_mute_frames(2), .C_auto_frames(3), .C_vs_active_high(1)) u_b (
    .clk_pixel_i(clk), .reset_n_i(rst_n), .btn_i(btn_b), .vsync_i(vsync),
    .mode_o(mode_b), .mute_o(mute_b), .mode_strobe_o(strobe_b), .busy_o(busy_b));

  always #5 clk = ~clk;

  // 100-clock frames, 4-clock active-high vsync pulse at the start of each frame.
  always @(posedge clk) begin
    if (pix_cnt == 99) begin
      pix_cnt  <= 0;
      frame_no <= frame_no + 1;
    end else begin
      pix_cnt <= pix_cnt + 1;
    end
  end
  assign vsync = (pix_cnt < 4);

  // Log auto-cycle steps of instance B.
  always @(negedge clk) begin
    if (rst_n && strobe_b) begin
      obs_b_mode.push_back(mode_b);
      obs_b_frame.push_back(frame_no);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Return on the cycle after the next frame edge has been acted on.
  task automatic wait_edges(input int n);
    repeat (n) begin
      @(negedge clk);
      while (pix_cnt != 1) @(negedge clk);
    end
  endtask

  task automatic press_btn(input int hi, input bit accept);
    if (accept) begin
      exp_mode_a = (exp_mode_a == 7) ? 0 : exp_mode_a + 1;
      exp_q.push_back(3'(exp_mode_a));
    end
    btn = 1'b1;
    step_clk(hi);
    btn = 1'b0;
    step_clk(16);
  endtask

  task automatic wait_strobe(input string tag, output int frm);
    int n = 0;
    frm = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!strobe_a && n < 400);
    chk({tag, "_seen"}, int'(strobe_a), 1);
    if (strobe_a) begin
      frm = frame_no;
      chk({tag, "_at_edge"}, pix_cnt, 1);
      if (exp_q.size() > 0) chk({tag, "_mode"}, int'(mode_a), int'(exp_q.pop_front()));
      else chk({tag, "_unexpected"}, int'(strobe_a), 0);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_a && n < 600);
    chk({tag, "_idle"}, int'(busy_a), 0);
  endtask

  initial begin
    int f1, f2, nstrobe;
    // Reset
    step_clk(3);
    chk("rst_mode_a", int'(mode_a), 4);
    chk("rst_mute_a", int'(mute_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_strobe_a", int'(strobe_a), 0);
    chk("rst_mode_b", int'(mode_b), 4);
    exp_b_q.push_back(3'd0);
    exp_b_q.push_back(3'd1);
    exp_b_q.push_back(3'd2);
    rst_n = 1'b1;

    // 1: five quiet frames
    nstrobe = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (strobe_a) nstrobe++;
    end
    chk("quiet_strobes", nstrobe, 0);
    chk("quiet_mode", int'(mode_a), 4);
    chk("quiet_mute", int'(mute_a), 0);
    chk("quiet_busy", int'(busy_a), 0);

    // 2: 8-clock press at frame 1.2, latency to mute/mode/unmute
    wait_edges(1);
    step_clk(19);
    press_btn(8, 1'b1);
    chk("t2_armed_busy", int'(busy_a), 1);
    chk("t2_armed_mute", int'(mute_a), 0);
    wait_edges(1);
    chk("t2_e2_mute", int'(mute_a), 1);
    chk("t2_e2_mode", int'(mode_a), 4);
    wait_strobe("t2_strobe", f1);
    wait_edges(1);
    chk("t2_e4_mute", int'(mute_a), 1);
    wait_edges(1);
    chk("t2_e5_mute", int'(mute_a), 0);
    chk("t2_e5_busy", int'(busy_a), 0);

    // 3: short glitch ignored, bounce then stable -> one step
    step_clk(20);
    btn = 1'b1; step_clk(6); btn = 1'b0;
    step_clk(30);
    chk("t3_glitch_busy", int'(busy_a), 0);
    chk("t3_glitch_mode", int'(mode_a), 5);
    btn = 1'b1; step_clk(1); btn = 1'b0; step_clk(2);
    btn = 1'b1; step_clk(2); btn = 1'b0; step_clk(1);
    btn = 1'b1; step_clk(3); btn = 1'b0; step_clk(2);
    press_btn(12, 1'b1);
    wait_strobe("t3_bounce", f1);
    wait_idle("t3");
    chk("t3_mode", int'(mode_a), 6);
    chk("t3_queue_empty", exp_q.size(), 0);

    // 4: 6->7->0 wrap
    press_btn(12, 1'b1);
    wait_strobe("t4_to7", f1);
    wait_idle("t4a");
    press_btn(12, 1'b1);
    wait_strobe("t4_wrap", f1);
    wait_idle("t4b");
    chk("t4_mode", int'(mode_a), 0);

    // 5: press + two presses while busy -> two back-to-back steps
    press_btn(12, 1'b1);
    step_clk(10);
    chk("t5_busy", int'(busy_a), 1);
    press_btn(12, 1'b1);
    press_btn(12, 1'b0);
    wait_strobe("t5_first", f1);
    wait_edges(2);
    chk("t5_rearm_busy", int'(busy_a), 1);
    chk("t5_rearm_mute", int'(mute_a), 0);
    wait_strobe("t5_second", f2);
    chk("t5_spacing", f2 - f1, 4);
    wait_idle("t5");
    step_clk(300);
    chk("t5_mode", int'(mode_a), 2);
    chk("t5_busy_end", int'(busy_a), 0);
    chk("t5_queue_empty", exp_q.size(), 0);

    // 6: reset during MUTE
    press_btn(12, 1'b1);
    wait_strobe("t6_strobe", f1);
    step_clk(10);
    chk("t6_mute_before", int'(mute_a), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_mute", int'(mute_a), 0);
    chk("t6_rst_mode", int'(mode_a), 4);
    chk("t6_rst_busy", int'(busy_a), 0);
    chk("t6_rst_mode_b", int'(mode_b), 4);

    // Auto-cycle of instance B: 4->0->1->2 (5 modes), 7 frames apart
    chk("b_count_ok", int'(obs_b_mode.size() >= 3), 1);
    if (obs_b_mode.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("b_mode%0d", i), int'(obs_b_mode[i]), int'(exp_b_q[i]));
        if (i > 0) chk($sformatf("b_period%0d", i), obs_b_frame[i] - obs_b_frame[i-1], 7);
      end
    end
    step_clk(3);
    rst_n = 1'b1;
    step_clk(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
